// File: rtl/mux_nto1_pipe.sv
// N-to-1 operand select mux with a 1- or 2-stage registered output pipeline.
// Tracks beat validity, supports whole-pipe stall and flush, flags an
// out-of-range select, and counts consecutive stalled cycles with valid output.
// STAGES must be 1 or 2; any value other than 2 builds a single stage.
module mux_nto1_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned STAGES  = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_SRC*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     sel_err,
    output logic [CNT_W-1:0]         stall_cnt
);

    logic [WIDTH-1:0] mux_c;
    logic             err_c;

    logic             v0_q;
    logic [WIDTH-1:0] d0_q;
    logic [SEL_W-1:0] s0_q;
    logic             e0_q;

    // Source select; an unmatched sel falls back to source 0 and raises err
    always_comb begin
        mux_c = in_data[WIDTH-1:0];
        err_c = 1'b1;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_c = in_data[i*WIDTH +: WIDTH];
                err_c = 1'b0;
            end
        end
    end

    // Stage 0: reset/flush clear, stall holds, otherwise load (bubbles carry zero payload)
    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            v0_q <= 1'b0;
            d0_q <= '0;
            s0_q <= '0;
            e0_q <= 1'b0;
        end else if (!stall) begin
            v0_q <= in_valid;
            d0_q <= in_valid ? mux_c : '0;
            s0_q <= in_valid ? sel   : '0;
            e0_q <= in_valid & err_c;
        end
    end

    generate
        if (STAGES == 2) begin : g_two
            logic             v1_q;
            logic [WIDTH-1:0] d1_q;
            logic [SEL_W-1:0] s1_q;
            logic             e1_q;

            // Stage 1: follows stage 0 under the same clear/hold rules
            always_ff @(posedge Clk) begin
                if (Rst || flush) begin
                    v1_q <= 1'b0;
                    d1_q <= '0;
                    s1_q <= '0;
                    e1_q <= 1'b0;
                end else if (!stall) begin
                    v1_q <= v0_q;
                    d1_q <= d0_q;
                    s1_q <= s0_q;
                    e1_q <= e0_q;
                end
            end

            assign out_valid = v1_q;
            assign out_data  = d1_q;
            assign out_sel   = s1_q;
            assign sel_err   = e1_q;
        end else begin : g_one
            assign out_valid = v0_q;
            assign out_data  = d0_q;
            assign out_sel   = s0_q;
            assign sel_err   = e0_q;
        end
    endgenerate

    // Saturating count of consecutive stalled cycles holding a valid output
    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            stall_cnt <= '0;
        end else if (stall && out_valid) begin
            if (!(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench for mux_nto1_pipe: a table-driven run on the default
// single-stage configuration plus directed sequences on a 3-source,
// 2-stage, 3-bit-counter configuration.
module tb_mux_nto1_pipe;

    logic Clk;
    int   checks;
    int   errors;

    // Instance A: defaults (WIDTH=32, NUM_SRC=4, SEL_W=2, STAGES=1, CNT_W=8)
    logic         a_rst;
    logic [127:0] a_in_data;
    logic [1:0]   a_sel;
    logic         a_in_valid, a_stall, a_flush;
    logic [31:0]  a_out_data;
    logic         a_out_valid, a_sel_err;
    logic [1:0]   a_out_sel;
    logic [7:0]   a_stall_cnt;

    // Instance B: NUM_SRC=3, STAGES=2, CNT_W=3
    logic         b_rst;
    logic [95:0]  b_in_data;
    logic [1:0]   b_sel;
    logic         b_in_valid, b_stall, b_flush;
    logic [31:0]  b_out_data;
    logic         b_out_valid, b_sel_err;
    logic [1:0]   b_out_sel;
    logic [2:0]   b_stall_cnt;

    mux_nto1_pipe u_a (
        .Clk(Clk), .Rst(a_rst), .in_data(a_in_data), .sel(a_sel),
        .in_valid(a_in_valid), .stall(a_stall), .flush(a_flush),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_sel(a_out_sel),
        .sel_err(a_sel_err), .stall_cnt(a_stall_cnt)
    );

    mux_nto1_pipe #(.WIDTH(32), .NUM_SRC(3), .SEL_W(2), .STAGES(2), .CNT_W(3)) u_b (
        .Clk(Clk), .Rst(b_rst), .in_data(b_in_data), .sel(b_sel),
        .in_valid(b_in_valid), .stall(b_stall), .flush(b_flush),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_sel(b_out_sel),
        .sel_err(b_sel_err), .stall_cnt(b_stall_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  sel;
        logic        vld;
        logic        stl;
        logic        fl;
        logic [31:0] ed;
        logic        ev;
        logic [1:0]  es;
        logic        ee;
        logic [7:0]  ec;
    } vec_t;

    vec_t vt [12];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input logic [31:0] ed, input logic ev,
                         input logic [1:0] es, input logic ee, input logic [2:0] ec);
        chk({nm, ".data"},  b_out_data, ed);
        chk({nm, ".valid"}, 32'(b_out_valid), 32'(ev));
        chk({nm, ".sel"},   32'(b_out_sel), 32'(es));
        chk({nm, ".err"},   32'(b_sel_err), 32'(ee));
        chk({nm, ".cnt"},   32'(b_stall_cnt), 32'(ec));
    endtask

    // Beat k offers base+0/+1/+2 on sources 0/1/2, so selecting s yields base+s
    function automatic logic [31:0] beat_base(input int k);
        return 32'h0100_0000 * 32'(k) + 32'h0000_1000;
    endfunction

    task automatic present_b(input logic vld, input int k, input logic [1:0] s);
        logic [31:0] base;
        base       = beat_base(k);
        b_in_data  = {base + 32'd2, base + 32'd1, base};
        b_sel      = s;
        b_in_valid = vld;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        a_rst = 1'b1; a_in_data = '0; a_sel = '0; a_in_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
        b_rst = 1'b1; b_in_data = '0; b_sel = '0; b_in_valid = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
        tick();
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Reset state
        chk("a_rst.data",  a_out_data, 32'h0);
        chk("a_rst.valid", 32'(a_out_valid), 32'h0);
        chk("a_rst.sel",   32'(a_out_sel), 32'h0);
        chk("a_rst.err",   32'(a_sel_err), 32'h0);
        chk("a_rst.cnt",   32'(a_stall_cnt), 32'h0);
        chk_b("b_rst", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);

        // Instance A table: single stage, output reflects the vector applied on the last edge
        a_in_data = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        vt[0]  = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 2'd0, 1'b0, 8'd0};
        vt[1]  = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 1'b1, 2'd1, 1'b0, 8'd0};
        vt[2]  = '{2'd2, 1'b1, 1'b0, 1'b0, 32'h3333_3333, 1'b1, 2'd2, 1'b0, 8'd0};
        vt[3]  = '{2'd3, 1'b1, 1'b0, 1'b0, 32'h4444_4444, 1'b1, 2'd3, 1'b0, 8'd0};
        vt[4]  = '{2'd2, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 8'd0};
        vt[5]  = '{2'd1, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 1'b1, 2'd1, 1'b0, 8'd0};
        vt[6]  = '{2'd3, 1'b1, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 2'd1, 1'b0, 8'd1};
        vt[7]  = '{2'd0, 1'b1, 1'b1, 1'b0, 32'h2222_2222, 1'b1, 2'd1, 1'b0, 8'd2};
        vt[8]  = '{2'd0, 1'b1, 1'b0, 1'b0, 32'h1111_1111, 1'b1, 2'd0, 1'b0, 8'd0};
        vt[9]  = '{2'd3, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 8'd0};
        vt[10] = '{2'd3, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 8'd0};
        vt[11] = '{2'd3, 1'b1, 1'b0, 1'b0, 32'h4444_4444, 1'b1, 2'd3, 1'b0, 8'd0};

        for (int i = 0; i < 12; i++) begin
            a_sel      = vt[i].sel;
            a_in_valid = vt[i].vld;
            a_stall    = vt[i].stl;
            a_flush    = vt[i].fl;
            tick();
            chk($sformatf("a_vec%0d.data", i),  a_out_data, vt[i].ed);
            chk($sformatf("a_vec%0d.valid", i), 32'(a_out_valid), 32'(vt[i].ev));
            chk($sformatf("a_vec%0d.sel", i),   32'(a_out_sel), 32'(vt[i].es));
            chk($sformatf("a_vec%0d.err", i),   32'(a_sel_err), 32'(vt[i].ee));
            chk($sformatf("a_vec%0d.cnt", i),   32'(a_stall_cnt), 32'(vt[i].ec));
        end
        a_in_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0;

        // B: out-of-range select returns source 0 with err, bubble returns zeros
        b_in_data  = {32'h3C3C_3C3C, 32'h5A5A_5A5A, 32'hA5A5_A5A5};
        b_sel      = 2'd3;
        b_in_valid = 1'b1;
        tick();
        chk_b("b_oor_lat", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        b_in_valid = 1'b0;
        tick();
        chk_b("b_oor", 32'hA5A5_A5A5, 1'b1, 2'd3, 1'b1, 3'd0);
        tick();
        chk_b("b_oor_bub", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);

        // B: stream D0..D3, stall 5 cycles with D1 at the output
        present_b(1'b1, 0, 2'd0);
        tick();
        present_b(1'b1, 1, 2'd1);
        tick();
        chk_b("b_d0", beat_base(0), 1'b1, 2'd0, 1'b0, 3'd0);
        present_b(1'b1, 2, 2'd2);
        tick();
        chk_b("b_d1", beat_base(1) + 32'd1, 1'b1, 2'd1, 1'b0, 3'd0);
        b_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            present_b(1'b1, 9, 2'(i % 3));
            tick();
            chk_b($sformatf("b_stall%0d", i), beat_base(1) + 32'd1, 1'b1, 2'd1, 1'b0, 3'(i + 1));
        end
        b_stall = 1'b0;
        present_b(1'b1, 3, 2'd0);
        tick();
        chk_b("b_d2", beat_base(2) + 32'd2, 1'b1, 2'd2, 1'b0, 3'd0);
        present_b(1'b0, 0, 2'd0);
        tick();
        chk_b("b_d3", beat_base(3), 1'b1, 2'd0, 1'b0, 3'd0);
        tick();
        chk_b("b_drain", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);

        // B: counter saturates at 7 during a long stall
        present_b(1'b1, 4, 2'd1);
        tick();
        present_b(1'b0, 0, 2'd0);
        tick();
        chk_b("b_sat_pre", beat_base(4) + 32'd1, 1'b1, 2'd1, 1'b0, 3'd0);
        b_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("b_sat%0d.cnt", i), 32'(b_stall_cnt), (i + 1 > 7) ? 32'd7 : 32'(i + 1));
        end
        chk("b_sat_hold.data", b_out_data, beat_base(4) + 32'd1);
        b_stall = 1'b0;

        // B: flush wins over stall with both stages valid
        present_b(1'b1, 5, 2'd0);
        tick();
        present_b(1'b1, 6, 2'd2);
        tick();
        chk_b("b_fl_pre", beat_base(5), 1'b1, 2'd0, 1'b0, 3'd0);
        present_b(1'b1, 10, 2'd1);
        b_flush = 1'b1;
        b_stall = 1'b1;
        tick();
        chk_b("b_flush", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        b_flush = 1'b0;
        b_stall = 1'b0;
        present_b(1'b1, 7, 2'd1);
        tick();
        chk_b("b_fl_lat", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        present_b(1'b0, 0, 2'd0);
        tick();
        chk_b("b_fl_new", beat_base(7) + 32'd1, 1'b1, 2'd1, 1'b0, 3'd0);
        tick();

        // B: reset mid-stream under stall loses in-flight beats
        present_b(1'b1, 11, 2'd0);
        tick();
        present_b(1'b1, 12, 2'd1);
        tick();
        chk_b("b_rs_pre", beat_base(11), 1'b1, 2'd0, 1'b0, 3'd0);
        b_stall = 1'b1;
        tick();
        chk_b("b_rs_stl", beat_base(11), 1'b1, 2'd0, 1'b0, 3'd1);
        present_b(1'b1, 13, 2'd2);
        b_rst = 1'b1;
        tick();
        chk_b("b_rs", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        b_rst = 1'b0;
        b_stall = 1'b0;
        present_b(1'b0, 0, 2'd0);
        tick();
        chk_b("b_rs_a", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        present_b(1'b1, 14, 2'd2);
        tick();
        chk_b("b_rs_b", 32'h0, 1'b0, 2'd0, 1'b0, 3'd0);
        present_b(1'b0, 0, 2'd0);
        tick();
        chk_b("b_rs_new", beat_base(14) + 32'd2, 1'b1, 2'd2, 1'b0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
